// File: rtl/can_error_overload_ctrl.sv
// CAN error/overload frame sequencer with TEC/REC fault confinement.
// Everything advances only on samplePoint clocks; outputs decode registered state.
module can_error_overload_ctrl #(
  parameter int FLAG_LEN      = 6,
  parameter int DELIM_LEN     = 8,
  parameter int INTERM_LEN    = 3,
  parameter int CNT_W         = 9,
  parameter int PASSIVE_LIMIT = 128,
  parameter int BUSOFF_LIMIT  = 256,
  parameter int RECOV_SEQ     = 128,
  parameter int MAX_OVL       = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             samplePoint,
  input  logic             rxBit,
  input  logic             bitErro,
  input  logic             stuffErro,
  input  logic             crcErro,
  input  logic             formErro,
  input  logic             ackErro,
  input  logic             overloadFlag,
  input  logic             txRole,
  input  logic             txSuccess,
  input  logic             rxSuccess,
  output logic             txBit,
  output logic             erro,
  output logic             overload,
  output logic             interframe,
  output logic [1:0]       errState,
  output logic [CNT_W-1:0] tec,
  output logic [CNT_W-1:0] rec
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ERR_FLAG  = 4'd1;
  localparam logic [3:0] S_ERR_WAIT  = 4'd2;
  localparam logic [3:0] S_ERR_DELIM = 4'd3;
  localparam logic [3:0] S_OVL_FLAG  = 4'd4;
  localparam logic [3:0] S_OVL_WAIT  = 4'd5;
  localparam logic [3:0] S_OVL_DELIM = 4'd6;
  localparam logic [3:0] S_INTERM    = 4'd7;
  localparam logic [3:0] S_BUS_OFF   = 4'd8;

  localparam int BW      = $clog2(FLAG_LEN + DELIM_LEN + INTERM_LEN + 1);
  localparam int OW      = $clog2(MAX_OVL + 1);
  localparam int SW      = $clog2(RECOV_SEQ);
  localparam int RUN_LEN = 11;
  localparam int WW      = CNT_W + 1;

  localparam logic [WW-1:0]    PASS_W = WW'(PASSIVE_LIMIT);
  localparam logic [WW-1:0]    BOFF_W = WW'(BUSOFF_LIMIT);
  localparam logic [WW-1:0]    CMAX_W = WW'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] REC_FB = CNT_W'(PASSIVE_LIMIT - 9);

  logic [3:0]       state, state_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [OW-1:0]    ovl_cnt, ovl_n;
  logic             err_int, err_n;
  logic [3:0]       run_cnt, run_n;
  logic [SW-1:0]    seq_cnt, seq_n;
  logic [CNT_W-1:0] tec_n, rec_n;
  logic [WW-1:0]    tec_w, rec_w;
  logic [3:0]       tec_inc;
  logic             rec_inc, err_hit, any_err;

  assign any_err = !(bitErro & stuffErro & crcErro & formErro & ackErro);

  always_comb begin
    if (state == S_BUS_OFF)                        errState = 2'b10;
    else if ({1'b0, tec} >= PASS_W || {1'b0, rec} >= PASS_W) errState = 2'b01;
    else                                           errState = 2'b00;
  end

  always_comb begin
    state_n = state;   bcnt_n = bcnt;   ovl_n = ovl_cnt; err_n = err_int;
    run_n   = run_cnt; seq_n  = seq_cnt; tec_n = tec;    rec_n = rec;
    err_hit = 1'b0; tec_inc = 4'd0; rec_inc = 1'b0;
    tec_w   = '0;   rec_w   = '0;
    if (samplePoint) begin
      if (state == S_BUS_OFF) begin
        // recovery: RECOV_SEQ runs of 11 consecutive recessive bits
        if (!rxBit) run_n = '0;
        else if (run_cnt == 4'(RUN_LEN - 1)) begin
          run_n = '0;
          if (seq_cnt == SW'(RECOV_SEQ - 1)) begin
            state_n = S_IDLE; tec_n = '0; rec_n = '0;
            seq_n = '0; bcnt_n = '0; ovl_n = '0;
          end else seq_n = seq_cnt + SW'(1);
        end else run_n = run_cnt + 4'd1;
      end else begin
        case (state)
          S_IDLE: begin
            if (any_err) err_hit = 1'b1;
            else if (!overloadFlag) begin
              state_n = S_OVL_FLAG; bcnt_n = '0; ovl_n = ovl_cnt + OW'(1);
            end
          end
          S_ERR_FLAG: begin
            // a recessive echo of an active flag is our own bit error
            if (errState == 2'b00 && rxBit) begin
              bcnt_n = '0;
              if (txRole) tec_inc = 4'd8;
            end else if (bcnt == BW'(FLAG_LEN - 1)) begin
              state_n = S_ERR_WAIT; bcnt_n = '0;
            end else bcnt_n = bcnt + BW'(1);
          end
          S_ERR_WAIT: if (rxBit) begin state_n = S_ERR_DELIM; bcnt_n = '0; end
          S_ERR_DELIM: begin
            if (!rxBit) err_hit = 1'b1;
            else if (bcnt == BW'(DELIM_LEN - 2)) begin
              state_n = S_INTERM; bcnt_n = '0;
            end else bcnt_n = bcnt + BW'(1);
          end
          S_OVL_FLAG: begin
            if (bcnt == BW'(FLAG_LEN - 1)) begin
              state_n = S_OVL_WAIT; bcnt_n = '0;
            end else bcnt_n = bcnt + BW'(1);
          end
          S_OVL_WAIT: if (rxBit) begin state_n = S_OVL_DELIM; bcnt_n = '0; end
          S_OVL_DELIM: begin
            if (!rxBit) begin state_n = S_OVL_FLAG; bcnt_n = '0; end
            else if (bcnt == BW'(DELIM_LEN - 2)) begin
              state_n = S_INTERM; bcnt_n = '0;
            end else bcnt_n = bcnt + BW'(1);
          end
          S_INTERM: begin
            if (bcnt < BW'(INTERM_LEN - 1) && (!rxBit || !overloadFlag) &&
                ovl_cnt < OW'(MAX_OVL)) begin
              state_n = S_OVL_FLAG; bcnt_n = '0;
              ovl_n = ovl_cnt + OW'(1); err_n = 1'b0;
            end else if (bcnt == BW'(INTERM_LEN - 1)) begin
              state_n = S_IDLE; bcnt_n = '0; ovl_n = '0; err_n = 1'b0;
            end else bcnt_n = bcnt + BW'(1);
          end
          default: state_n = S_IDLE;
        endcase
        if (err_hit) begin
          state_n = S_ERR_FLAG; bcnt_n = '0; err_n = 1'b1;
          if (txRole) tec_inc = 4'd8;
          else        rec_inc = 1'b1;
        end
        // success decrements first, then error increments with saturation
        tec_w = {1'b0, tec};
        if (txSuccess && tec != '0) tec_w = tec_w - WW'(1);
        tec_w = tec_w + WW'(tec_inc);
        if (tec_w > CMAX_W) tec_w = CMAX_W;
        rec_w = {1'b0, rec};
        if (rxSuccess) begin
          if ({1'b0, rec} >= PASS_W) rec_w = {1'b0, REC_FB};
          else if (rec != '0)        rec_w = rec_w - WW'(1);
        end
        rec_w = rec_w + WW'(rec_inc);
        if (rec_w > CMAX_W) rec_w = CMAX_W;
        tec_n = tec_w[CNT_W-1:0];
        rec_n = rec_w[CNT_W-1:0];
        if (tec_w >= BOFF_W) begin
          state_n = S_BUS_OFF; bcnt_n = '0; run_n = '0;
          seq_n = '0; err_n = 1'b0; ovl_n = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE; bcnt <= '0; ovl_cnt <= '0; err_int <= 1'b0;
      run_cnt <= '0; seq_cnt <= '0; tec <= '0; rec <= '0;
    end else begin
      state <= state_n; bcnt <= bcnt_n; ovl_cnt <= ovl_n; err_int <= err_n;
      run_cnt <= run_n; seq_cnt <= seq_n; tec <= tec_n; rec <= rec_n;
    end
  end

  assign txBit      = !((state == S_ERR_FLAG && errState == 2'b00) || state == S_OVL_FLAG);
  assign erro       = !err_int;
  assign overload   = (state == S_OVL_FLAG) || (state == S_OVL_WAIT) || (state == S_OVL_DELIM);
  assign interframe = (state == S_IDLE) || (state == S_INTERM);

endmodule

// File: tb/tb_can_error_overload_ctrl.sv
// Bench for can_error_overload_ctrl: frame-phase model with countdowns,
// compared every clock, plus directed literal checks and random traffic.
module tb_can_error_overload_ctrl;
  logic clock = 1'b0;
  logic reset, samplePoint, rxBit, bitErro, stuffErro, crcErro, formErro, ackErro;
  logic overloadFlag, txRole, txSuccess, rxSuccess;
  logic txBit, erro, overload, interframe;
  logic [1:0] errState;
  logic [8:0] tec, rec;
  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  can_error_overload_ctrl dut (
    .clock(clock), .reset(reset), .samplePoint(samplePoint), .rxBit(rxBit),
    .bitErro(bitErro), .stuffErro(stuffErro), .crcErro(crcErro),
    .formErro(formErro), .ackErro(ackErro), .overloadFlag(overloadFlag),
    .txRole(txRole), .txSuccess(txSuccess), .rxSuccess(rxSuccess),
    .txBit(txBit), .erro(erro), .overload(overload), .interframe(interframe),
    .errState(errState), .tec(tec), .rec(rec));

  localparam int P_IDLE = 0, P_EFLAG = 1, P_EWAIT = 2, P_EDELIM = 3;
  localparam int P_OFLAG = 4, P_OWAIT = 5, P_ODELIM = 6, P_INTERM = 7, P_BOFF = 8;
  int ph, left, novl, run, runs, mt, mr;
  bit in_err;

  function automatic int m_es();
    if (ph == P_BOFF) return 2;
    return (mt >= 128 || mr >= 128) ? 1 : 0;
  endfunction
  function automatic bit exp_tx();
    return !((ph == P_EFLAG && m_es() == 0) || ph == P_OFLAG);
  endfunction
  function automatic bit exp_erro();
    return !(ph == P_EFLAG || ph == P_EWAIT || ph == P_EDELIM || (ph == P_INTERM && in_err));
  endfunction
  function automatic bit exp_ovl();
    return ph == P_OFLAG || ph == P_OWAIT || ph == P_ODELIM;
  endfunction
  function automatic bit exp_if();
    return ph == P_IDLE || ph == P_INTERM;
  endfunction

  task automatic m_reset();
    ph = P_IDLE; left = 0; novl = 0; run = 0; runs = 0; mt = 0; mr = 0; in_err = 0;
  endtask

  task automatic m_update();
    int es, tinc, rinc;
    bit any_e, go_err;
    if (reset) begin m_reset(); return; end
    if (!samplePoint) return;
    if (ph == P_BOFF) begin
      if (rxBit) begin
        run++;
        if (run == 11) begin
          run = 0; runs++;
          if (runs == 128) begin ph = P_IDLE; mt = 0; mr = 0; runs = 0; end
        end
      end else run = 0;
      return;
    end
    es = m_es(); tinc = 0; rinc = 0; go_err = 0;
    any_e = !(bitErro && stuffErro && crcErro && formErro && ackErro);
    case (ph)
      P_IDLE: begin
        if (any_e) go_err = 1;
        else if (!overloadFlag) begin ph = P_OFLAG; left = 6; novl++; end
      end
      P_EFLAG: begin
        if (es == 0 && rxBit) begin left = 6; if (txRole) tinc = 8; end
        else begin left--; if (left == 0) ph = P_EWAIT; end
      end
      P_EWAIT: if (rxBit) begin ph = P_EDELIM; left = 7; end
      P_EDELIM: begin
        if (!rxBit) go_err = 1;
        else begin left--; if (left == 0) begin ph = P_INTERM; left = 3; end end
      end
      P_OFLAG: begin left--; if (left == 0) ph = P_OWAIT; end
      P_OWAIT: if (rxBit) begin ph = P_ODELIM; left = 7; end
      P_ODELIM: begin
        if (!rxBit) begin ph = P_OFLAG; left = 6; end
        else begin left--; if (left == 0) begin ph = P_INTERM; left = 3; end end
      end
      P_INTERM: begin
        if ((4 - left) < 3 && (!rxBit || !overloadFlag) && novl < 2) begin
          ph = P_OFLAG; left = 6; novl++; in_err = 0;
        end else begin
          left--;
          if (left == 0) begin ph = P_IDLE; novl = 0; in_err = 0; end
        end
      end
      default: ;
    endcase
    if (go_err) begin
      ph = P_EFLAG; left = 6; in_err = 1;
      if (txRole) tinc = 8; else rinc = 1;
    end
    if (txSuccess && mt > 0) mt--;
    if (rxSuccess) begin
      if (mr >= 128) mr = 119; else if (mr > 0) mr--;
    end
    mt = (mt + tinc > 511) ? 511 : mt + tinc;
    mr = (mr + rinc > 511) ? 511 : mr + rinc;
    if (mt >= 256) begin ph = P_BOFF; run = 0; runs = 0; in_err = 0; novl = 0; end
  endtask

  task automatic compare();
    n_chk++;
    if (txBit !== exp_tx() || erro !== exp_erro() || overload !== exp_ovl() ||
        interframe !== exp_if() || errState !== 2'(m_es()) ||
        tec !== 9'(mt) || rec !== 9'(mr)) begin
      n_fail++;
      $display("FAIL cycle t=%0t dut tx=%b erro=%b ovl=%b if=%b es=%0d tec=%0d rec=%0d | model tx=%b erro=%b ovl=%b if=%b es=%0d tec=%0d rec=%0d",
               $time, txBit, erro, overload, interframe, errState, tec, rec,
               exp_tx(), exp_erro(), exp_ovl(), exp_if(), m_es(), mt, mr);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit sp);
    samplePoint = sp;
    @(posedge clock);
    m_update();
    @(negedge clock);
    compare();
  endtask

  task automatic sample();
    repeat ($urandom_range(0, 1)) step(0);
    step(1);
  endtask

  task automatic quiet();
    reset = 0; bitErro = 1; stuffErro = 1; crcErro = 1; formErro = 1; ackErro = 1;
    overloadFlag = 1; txSuccess = 0; rxSuccess = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; step(0); reset = 0;
  endtask

  task automatic drive_echo(input int n);
    for (int i = 0; i < n; i++) begin rxBit = exp_tx(); sample(); end
  endtask

  initial begin
    int zeros, first, guard;
    m_reset();
    quiet(); rxBit = 1; txRole = 0; samplePoint = 0;
    @(negedge clock);
    do_reset();
    check("rst txBit", int'(txBit), 1);
    check("rst erro", int'(erro), 1);
    check("rst overload", int'(overload), 0);
    check("rst interframe", int'(interframe), 1);
    check("rst errState", int'(errState), 0);
    check("rst tec/rec", int'(tec) + int'(rec), 0);

    // 1: transmitter stuff error, active flag, delimiter, intermission
    stuffErro = 0; txRole = 1; rxBit = 1; sample(); stuffErro = 1;
    check("t1 tec", int'(tec), 8);
    zeros = (txBit == 1'b0) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin rxBit = exp_tx(); sample(); if (txBit == 1'b0) zeros++; end
    check("t1 flag bits", zeros, 6);
    check("t1 flag end", int'(txBit), 1);
    first = 0; rxBit = 1;
    for (int i = 1; i <= 11; i++) begin sample(); if (first == 0 && erro == 1'b1) first = i; end
    check("t1 erro back", first, 11);

    // 2: receiver errors up to the passive boundary
    do_reset(); txRole = 0; guard = 0;
    while (!(mr == 127 && ph == P_IDLE) && guard < 4000) begin
      crcErro = (ph == P_IDLE && mr < 127) ? 1'b0 : 1'b1;
      rxBit = exp_tx(); sample(); guard++;
    end
    crcErro = 1;
    check("t2 reach 127", int'(rec), 127);
    check("t2 errState 00", int'(errState), 0);
    crcErro = 0; rxBit = 1; sample(); crcErro = 1;
    check("t2 rec", int'(rec), 128);
    check("t2 errState 01", int'(errState), 1);
    check("t2 passive flag", int'(txBit), 1);
    rxSuccess = 1; rxBit = exp_tx(); sample(); rxSuccess = 0;
    check("t2 rec fallback", int'(rec), 119);

    // 3: overload frames, third request ignored
    do_reset(); overloadFlag = 0; rxBit = 1; sample(); overloadFlag = 1;
    check("t3 overload", int'(overload), 1);
    check("t3 ovl flag", int'(txBit), 0);
    drive_echo(14);
    check("t3 interm", int'(interframe), 1);
    overloadFlag = 0; rxBit = 1; sample(); overloadFlag = 1;
    check("t3 second ovl", int'(overload), 1);
    drive_echo(14);
    overloadFlag = 0; rxBit = 1; sample();
    check("t3 third ignored", int'(overload), 0);
    sample(); overloadFlag = 1; sample();
    check("t3 interframe", int'(interframe), 1);
    overloadFlag = 0; sample(); overloadFlag = 1;
    check("t3 fresh ovl", int'(overload), 1);

    // 4: bus-off and recovery
    do_reset(); txRole = 1; guard = 0;
    while (!(mt == 248 && ph == P_IDLE) && guard < 3000) begin
      stuffErro = (ph == P_IDLE && mt < 248) ? 1'b0 : 1'b1;
      rxBit = exp_tx(); sample(); guard++;
    end
    stuffErro = 1;
    check("t4 reach 248", int'(tec), 248);
    bitErro = 0; rxBit = 1; sample();
    check("t4 tec", int'(tec), 256);
    check("t4 busoff", int'(errState), 2);
    check("t4 txBit", int'(txBit), 1);
    stuffErro = 0; crcErro = 0; formErro = 0; ackErro = 0; overloadFlag = 0;
    for (int i = 0; i < 128 * 11 - 1; i++) step(1);
    check("t4 still busoff", int'(errState), 2);
    step(1);
    check("t4 recovered tec", int'(tec), 0);
    check("t4 recovered rec", int'(rec), 0);
    check("t4 recovered es", int'(errState), 0);
    quiet();

    // 5: no samplePoint means no change; reset mid error flag
    do_reset(); stuffErro = 0; txRole = 1; rxBit = 1; sample();
    bitErro = 0; crcErro = 0; formErro = 0; ackErro = 0; overloadFlag = 0;
    for (int i = 0; i < 20; i++) begin rxBit = 1'($urandom_range(0, 1)); step(0); end
    check("t5 hold tec", int'(tec), 8);
    check("t5 hold flag", int'(txBit), 0);
    reset = 1; step(0); reset = 0;
    check("t5 reset tec", int'(tec), 0);
    check("t5 reset txBit", int'(txBit), 1);
    check("t5 reset erro", int'(erro), 1);
    quiet();

    // random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      bitErro      = ($urandom_range(0, 39) != 0);
      stuffErro    = ($urandom_range(0, 39) != 0);
      crcErro      = ($urandom_range(0, 39) != 0);
      formErro     = ($urandom_range(0, 39) != 0);
      ackErro      = ($urandom_range(0, 39) != 0);
      overloadFlag = ($urandom_range(0, 9) != 0);
      txRole       = 1'($urandom_range(0, 1));
      txSuccess    = ($urandom_range(0, 19) == 0);
      rxSuccess    = ($urandom_range(0, 19) == 0);
      rxBit        = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 7) != 0) : exp_tx();
      step($urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
